// File: rtl/bmx_wrr_sched.sv
// Weighted round-robin address-channel scheduler: registered one-hot grant,
// per-requester credits and per-requester outstanding-transaction limiting.
module bmx_wrr_sched #(
  parameter int N     = 3,
  parameter int WW    = 4,
  parameter int OTW   = 4,
  parameter int MAXOT = 8,
  parameter int IW    = $clog2(N)
) (
  input  logic            hclk,
  input  logic            reset,
  input  logic [N-1:0]    req,
  input  logic [N*WW-1:0] weight,
  input  logic            addr_hs,
  input  logic            resp_done,
  input  logic [IW-1:0]   resp_id,
  output logic [N-1:0]    gnt,
  output logic            gnt_vld,
  output logic [IW-1:0]   gnt_idx,
  output logic [N*OTW-1:0] ot_cnt,
  output logic            err
);

  localparam int unsigned NU = N;

  typedef enum logic [1:0] {IDLE, REFILL, GRANT} state_t;

  state_t           state;
  logic [WW-1:0]    credit [N];
  logic [OTW-1:0]   ot     [N];
  logic [IW-1:0]    ptr;

  logic [N-1:0]     elig;
  logic [N-1:0]     inc;
  logic [N-1:0]     dec;
  logic             bad_resp;
  logic             hit_c, hit_e;
  logic [IW-1:0]    pick_c, pick_e;

  // pick_c: first eligible with credit from ptr; pick_e: first eligible at all,
  // used on the refill cycle where every eligible requester gets fresh credit.
  always_comb begin
    elig   = '0;
    hit_c  = 1'b0;
    hit_e  = 1'b0;
    pick_c = '0;
    pick_e = '0;
    for (int unsigned i = 0; i < NU; i++) begin
      elig[i] = req[i] && (weight[i*WW +: WW] != '0) && (ot[i] < OTW'(MAXOT));
    end
    for (int unsigned k = 0; k < NU; k++) begin
      int unsigned j;
      j = (32'(ptr) + k) % NU;
      if (!hit_c && elig[j] && (credit[j] != '0)) begin
        hit_c  = 1'b1;
        pick_c = IW'(j);
      end
      if (!hit_e && elig[j]) begin
        hit_e  = 1'b1;
        pick_e = IW'(j);
      end
    end
  end

  always_comb begin
    inc    = '0;
    dec    = '0;
    ot_cnt = '0;
    for (int unsigned i = 0; i < NU; i++) begin
      inc[i] = gnt_vld && addr_hs && (gnt_idx == IW'(i));
      dec[i] = resp_done && (32'(resp_id) == i) && (ot[i] != '0);
      ot_cnt[i*OTW +: OTW] = ot[i];
    end
    bad_resp = resp_done && !(|dec);
  end

  always_ff @(posedge hclk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      ptr     <= '0;
      gnt     <= '0;
      gnt_vld <= 1'b0;
      gnt_idx <= '0;
      err     <= 1'b0;
      for (int unsigned i = 0; i < NU; i++) begin
        credit[i] <= '0;
        ot[i]     <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NU; i++) begin
        if (inc[i] && !dec[i])
          ot[i] <= ot[i] + 1'b1;
        else if (dec[i] && !inc[i])
          ot[i] <= ot[i] - 1'b1;
      end
      if (bad_resp)
        err <= 1'b1;

      case (state)
        IDLE: begin
          if (hit_c) begin
            gnt     <= N'(1) << pick_c;
            gnt_idx <= pick_c;
            gnt_vld <= 1'b1;
            state   <= GRANT;
          end else if (|elig) begin
            state <= REFILL;
          end
        end
        // The refill cycle also issues the grant the following idle cycle would
        // make, giving the two-cycle first-grant latency.
        REFILL: begin
          for (int unsigned i = 0; i < NU; i++)
            credit[i] <= weight[i*WW +: WW];
          if (hit_e) begin
            gnt     <= N'(1) << pick_e;
            gnt_idx <= pick_e;
            gnt_vld <= 1'b1;
            state   <= GRANT;
          end else begin
            state <= IDLE;
          end
        end
        GRANT: begin
          if (addr_hs) begin
            credit[gnt_idx] <= credit[gnt_idx] - 1'b1;
            if (credit[gnt_idx] == WW'(1))
              ptr <= (gnt_idx == IW'(N-1)) ? '0 : gnt_idx + 1'b1;
            else
              ptr <= gnt_idx;
            gnt     <= '0;
            gnt_vld <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
